// File: rtl/siso8_ring.sv
// Serial-in/serial-out delay line: a 2*JW-cell circular buffer addressed by a
// JW-bit Johnson counter, giving a fixed delay of 2*JW enabled samples.

module siso8_pdec (
  input  logic i_a,
  input  logic i_b,
  output logic o_p
);
  assign o_p = i_a & i_b;
endmodule

module siso8_ring #(
  parameter int JW = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            EN,
  input  logic            D_IN,
  output logic            D_OUT,
  output logic [JW-1:0]   JOHNSON,
  output logic [2*JW-1:0] PULSES,
  output logic            PRIMED
);
  localparam int N  = 2 * JW;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N) + 1;

  // Johnson state for sequence position i: ones fill from the LSB, then drain.
  function automatic logic [JW-1:0] jstate(input int i);
    logic [JW-1:0] s;
    for (int b = 0; b < JW; b++)
      s[b] = (i <= JW) ? (b < i) : (b >= i - JW);
    return s;
  endfunction

  logic [JW-1:0] r_john;
  logic [N-1:0]  r_mem;
  logic          r_dout;
  logic          r_prim;
  logic [CW-1:0] r_cnt;

  logic [N-1:0]  w_match;
  logic [N-1:0]  w_raw;
  logic [N-1:0]  w_pa;
  logic [N-1:0]  w_pb;
  logic          w_legal;
  logic [IW-1:0] w_idx;
  logic [JW-1:0] w_jnext;

  // Each pulse is the AND of one adjacent bit pair, so only one input changes per step.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign w_match[gi] = (r_john == jstate(gi));
      if (gi == 0) begin : g_p0
        assign w_pa[gi] = ~r_john[JW-1];
        assign w_pb[gi] = ~r_john[0];
      end else if (gi < JW) begin : g_rise
        assign w_pa[gi] =  r_john[gi-1];
        assign w_pb[gi] = ~r_john[gi];
      end else if (gi == JW) begin : g_full
        assign w_pa[gi] =  r_john[JW-1];
        assign w_pb[gi] =  r_john[0];
      end else begin : g_fall
        assign w_pa[gi] = ~r_john[gi-JW-1];
        assign w_pb[gi] =  r_john[gi-JW];
      end
      siso8_pdec u_pdec (
        .i_a (w_pa[gi]),
        .i_b (w_pb[gi]),
        .o_p (w_raw[gi])
      );
    end
  endgenerate

  assign w_legal = |w_match;
  assign w_jnext = {r_john[JW-2:0], ~r_john[JW-1]};

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N; i++)
      if (w_match[i]) w_idx = IW'(i);
  end

  // Recovery from an upset state takes priority over EN and leaves the buffer alone.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_john <= '0;
      r_mem  <= '0;
      r_dout <= 1'b0;
      r_prim <= 1'b0;
      r_cnt  <= '0;
    end else if (!w_legal) begin
      r_john <= '0;
      r_prim <= 1'b0;
      r_cnt  <= '0;
    end else if (EN) begin
      r_mem[w_idx] <= D_IN;
      r_dout       <= r_mem[w_idx];
      r_john       <= w_jnext;
      if (r_cnt != CW'(N)) r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(N - 1)) r_prim <= 1'b1;
    end
  end

  assign D_OUT   = r_dout;
  assign JOHNSON = r_john;
  assign PULSES  = w_raw & {N{w_legal}};
  assign PRIMED  = r_prim;

endmodule

// File: tb/tb_siso8_ring.sv
// Scoreboard bench for siso8_ring: expected D_OUT pushed as stimulus is driven,
// popped and compared after each clock edge.

module tb_siso8_ring;
  localparam int JW = 4;
  localparam int N  = 2 * JW;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          EN = 1'b0;
  logic          D_IN = 1'b0;
  logic          D_OUT;
  logic [JW-1:0] JOHNSON;
  logic [N-1:0]  PULSES;
  logic          PRIMED;

  siso8_ring #(.JW(JW)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .EN      (EN),
    .D_IN    (D_IN),
    .D_OUT   (D_OUT),
    .JOHNSON (JOHNSON),
    .PULSES  (PULSES),
    .PRIMED  (PRIMED)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [JW-1:0] jseq [N] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                              4'b1111, 4'b1110, 4'b1100, 4'b1000};
  logic pat  [12] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1};
  logic pat2 [8]  = '{1, 1, 0, 1, 0, 0, 1, 0};

  logic model_q [$];
  logic exp_q   [$];
  logic exp_last;
  int   en_cnt;

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    for (int i = 0; i < N; i++) model_q.push_back(1'b0);
    exp_last = 1'b0;
    en_cnt   = 0;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    EN    = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    model_reset();
  endtask

  // Drive one cycle; scoreboard gets the D_OUT expected after this edge.
  task automatic step(input logic en, input logic din);
    EN   = en;
    D_IN = din;
    if (en) begin
      model_q.push_back(din);
      exp_last = model_q.pop_front();
      en_cnt++;
    end
    exp_q.push_back(exp_last);
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    logic e;
    RESET = 1'b0; EN = 1'b1; D_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (D_OUT !== 1'b0) begin failures++; $display("FAIL reset_dout got=%b exp=0", D_OUT); end
    checks++; if (JOHNSON !== 4'b0000) begin failures++; $display("FAIL reset_john got=%b exp=0000", JOHNSON); end
    checks++; if (PULSES !== 8'b00000001) begin failures++; $display("FAIL reset_pulses got=%b exp=00000001", PULSES); end
    checks++; if (PRIMED !== 1'b0) begin failures++; $display("FAIL reset_primed got=%b exp=0", PRIMED); end
    RESET = 1'b1;
    model_reset();
    step(1'b1, 1'b1);
    e = exp_q.pop_front();
    checks++; if (D_OUT !== e) begin failures++; $display("FAIL first_dout got=%b exp=%b", D_OUT, e); end
    checks++; if (JOHNSON !== 4'b0001) begin failures++; $display("FAIL first_john got=%b exp=0001", JOHNSON); end
    checks++; if (PULSES !== 8'b00000010) begin failures++; $display("FAIL first_pulses got=%b exp=00000010", PULSES); end
  endtask

  task automatic test_delay();
    logic e;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(1'b1, pat[k]);
      e = exp_q.pop_front();
      checks++; if (D_OUT !== e) begin failures++; $display("FAIL delay_dout edge=%0d got=%b exp=%b", en_cnt, D_OUT, e); end
      checks++; if (PRIMED !== (en_cnt >= N)) begin failures++; $display("FAIL delay_primed edge=%0d got=%b exp=%b", en_cnt, PRIMED, en_cnt >= N); end
      checks++; if (JOHNSON !== jseq[en_cnt % N]) begin failures++; $display("FAIL delay_john edge=%0d got=%b exp=%b", en_cnt, JOHNSON, jseq[en_cnt % N]); end
    end
  endtask

  task automatic test_en_gaps();
    logic e;
    int   k;
    int   cyc;
    do_reset();
    k = 0; cyc = 0;
    while (k < 12) begin
      if (cyc % 3 == 2) step(1'b0, 1'($urandom_range(0, 1)));
      else begin step(1'b1, pat[k]); k++; end
      cyc++;
      e = exp_q.pop_front();
      checks++; if (D_OUT !== e) begin failures++; $display("FAIL gap_dout cyc=%0d got=%b exp=%b", cyc, D_OUT, e); end
      checks++; if (JOHNSON !== jseq[en_cnt % N]) begin failures++; $display("FAIL gap_john cyc=%0d got=%b exp=%b", cyc, JOHNSON, jseq[en_cnt % N]); end
      checks++; if (PULSES !== (8'd1 << (en_cnt % N))) begin failures++; $display("FAIL gap_pulses cyc=%0d got=%b exp=%b", cyc, PULSES, 8'd1 << (en_cnt % N)); end
      checks++; if (PRIMED !== (en_cnt >= N)) begin failures++; $display("FAIL gap_primed cyc=%0d got=%b exp=%b", cyc, PRIMED, en_cnt >= N); end
    end
  endtask

  task automatic test_wrap();
    logic e;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      e = exp_q.pop_front();
      checks++; if (D_OUT !== e) begin failures++; $display("FAIL wrap_dout edge=%0d got=%b exp=%b", en_cnt, D_OUT, e); end
      checks++; if (JOHNSON !== jseq[en_cnt % N]) begin failures++; $display("FAIL wrap_john edge=%0d got=%b exp=%b", en_cnt, JOHNSON, jseq[en_cnt % N]); end
      checks++; if (PULSES !== (8'd1 << (en_cnt % N))) begin failures++; $display("FAIL wrap_pulses edge=%0d got=%b exp=%b", en_cnt, PULSES, 8'd1 << (en_cnt % N)); end
    end
  endtask

  task automatic test_reset_mid();
    logic e;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      step(1'b1, 1'b1);
      e = exp_q.pop_front();
      checks++; if (D_OUT !== e) begin failures++; $display("FAIL mid_pre_dout edge=%0d got=%b exp=%b", en_cnt, D_OUT, e); end
    end
    checks++; if (PRIMED !== 1'b1) begin failures++; $display("FAIL mid_pre_primed got=%b exp=1", PRIMED); end
    #2 RESET = 1'b0;
    #1;
    checks++; if (D_OUT !== 1'b0) begin failures++; $display("FAIL mid_async_dout got=%b exp=0", D_OUT); end
    checks++; if (JOHNSON !== 4'b0000) begin failures++; $display("FAIL mid_async_john got=%b exp=0000", JOHNSON); end
    checks++; if (PRIMED !== 1'b0) begin failures++; $display("FAIL mid_async_primed got=%b exp=0", PRIMED); end
    @(posedge CLK); #1;
    RESET = 1'b1;
    model_reset();
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 1'b1);
      e = exp_q.pop_front();
      checks++; if (D_OUT !== e) begin failures++; $display("FAIL mid_refill_dout edge=%0d got=%b exp=%b", en_cnt, D_OUT, e); end
      checks++; if (PRIMED !== (en_cnt >= N)) begin failures++; $display("FAIL mid_refill_primed edge=%0d got=%b exp=%b", en_cnt, PRIMED, en_cnt >= N); end
    end
  endtask

  task automatic test_illegal();
    logic e;
    do_reset();
    for (int k = 0; k < N; k++) begin
      step(1'b1, pat2[k]);
      void'(exp_q.pop_front());
    end
    checks++; if (PRIMED !== 1'b1) begin failures++; $display("FAIL ill_pre_primed got=%b exp=1", PRIMED); end
    EN = 1'b0;
    force dut.r_john = 4'b0101;
    #1;
    checks++; if (PULSES !== 8'b0) begin failures++; $display("FAIL ill_pulses got=%b exp=00000000", PULSES); end
    // EN high on the recovery edge must neither write cell 0 nor advance D_OUT.
    EN = 1'b1; D_IN = ~pat2[0];
    @(posedge CLK); #1;
    checks++; if (PRIMED !== 1'b0) begin failures++; $display("FAIL ill_primed got=%b exp=0", PRIMED); end
    checks++; if (D_OUT !== exp_last) begin failures++; $display("FAIL ill_dout_hold got=%b exp=%b", D_OUT, exp_last); end
    EN = 1'b0;
    release dut.r_john;
    @(posedge CLK); #1;
    checks++; if (JOHNSON !== 4'b0000) begin failures++; $display("FAIL ill_john got=%b exp=0000", JOHNSON); end
    checks++; if (PULSES !== 8'b00000001) begin failures++; $display("FAIL ill_pulses_rec got=%b exp=00000001", PULSES); end
    checks++; if (PRIMED !== 1'b0) begin failures++; $display("FAIL ill_primed_rec got=%b exp=0", PRIMED); end
    // Buffer still holds pat2, so draining it replays that pattern.
    en_cnt = 0;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      step(1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++; if (D_OUT !== e) begin failures++; $display("FAIL ill_drain_dout k=%0d got=%b exp=%b", k, D_OUT, e); end
      checks++; if (PRIMED !== (en_cnt >= N)) begin failures++; $display("FAIL ill_drain_primed k=%0d got=%b exp=%b", k, PRIMED, en_cnt >= N); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_delay();
    test_en_gaps();
    test_wrap();
    test_reset_mid();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
